// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path: segment width, blank code,
// hex glyph table and a ceiling-log2 helper for sizing counters.
package seg_pkg;

   localparam int SEG_W = 7;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   // {a,b,c,d,e,f,g}, 1 = segment lit
   localparam logic [SEG_W-1:0] HEX_SEG [0:15] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   function automatic int log2ceil(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to {a..g} segment pattern.
module hex_seg_decoder
   import seg_pkg::*;
(
   input  logic [3:0]       nib,
   output logic [SEG_W-1:0] seg
);

   assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: shadow-latches a value on load and swaps it
// onto the display only at frame start so digits never tear mid-scan.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load,
   input  logic                    lzb,
   input  logic                    en,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [SEG_W-1:0]        seg,
   output logic                    frame
);

   localparam int PW = log2ceil(REFRESH_DIV);
   localparam int IW = log2ceil(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]              presc;
   logic [IW-1:0]              idx, idx_next;
   logic [NUM_DIGITS-1:0][3:0] shadow, disp, disp_next;
   logic [NUM_DIGITS-1:0]      hi_zero;
   logic                       tick, frame_start, blank;
   logic [3:0]                 nib;
   logic [SEG_W-1:0]           dec_seg;

   assign tick        = (presc == PRESC_MAX);
   assign frame_start = tick && (idx == IDX_MAX);

   always_comb begin
      idx_next = idx;
      if (tick) idx_next = (idx == IDX_MAX) ? '0 : idx + IW'(1);
   end

   // A load on the frame-start cycle bypasses the shadow straight to disp
   assign disp_next = frame_start ? (load ? value_in : shadow) : disp;

   // hi_zero[i]: digit i and every more significant digit are zero
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_hi_zero
      assign hi_zero[i] = (disp_next[NUM_DIGITS-1:i] == '0);
   end

   assign nib   = disp_next[idx_next];
   assign blank = lzb && (idx_next != '0) && hi_zero[idx_next];

   hex_seg_decoder u_dec (
      .nib (nib),
      .seg (dec_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc  <= '0;
         idx    <= IDX_MAX;
         shadow <= '0;
         disp   <= '0;
         frame  <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         idx   <= idx_next;
         disp  <= disp_next;
         frame <= frame_start;
         if (load) shadow <= value_in;
      end
   end

   // an and seg share one register update so they never mismatch for a cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= '1;
         seg <= SEG_BLANK;
      end else if (!en) begin
         an  <= '1;
         seg <= SEG_BLANK;
      end else if (tick) begin
         an  <= ~(NUM_DIGITS'(1) << idx_next);
         seg <= blank ? SEG_BLANK : dec_seg;
      end
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller that drives a common-anode multi-digit seven-segment display from the multiplier's 16-bit product. It latches a hex value on a load strobe and copies it to the display only at frame boundaries, so a digit never tears mid-scan. It cycles the digit enables at a programmable refresh rate and routes each digit's nibble through a shared hex-to-segment decoder. It sits between the multiplier result register and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; value width is 4*NUM_DIGITS.
- REFRESH_DIV, 50000, clock cycles each digit stays enabled; minimum 2.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value_in  in  4*NUM_DIGITS  hex value; digit i shows value_in[4i+3:4i]; digit 0 is least significant.
- load  in  1  single-cycle strobe; captures value_in into the shadow register.
- lzb  in  1  leading-zero blanking enable.
- en  in  1  display enable; 0 blanks all digits.
- an  out  NUM_DIGITS  digit enables, active-low; an[i] selects digit i.
- seg  out  7  {a,b,c,d,e,f,g}, active-high (1 = lit).
- frame  out  1  one-cycle pulse, coincident with digit 0 becoming active.

## Operation
- Prescaler `presc` counts 0..REFRESH_DIV-1 and wraps. `tick` = (presc == REFRESH_DIV-1).
- Digit index `idx` advances on each tick: it wraps from NUM_DIGITS-1 to 0 and otherwise increments.
- Frame start is a tick where the next idx is 0. At frame start:
  - `disp` <= load ? value_in : shadow.
  - A load in the same cycle bypasses to disp and also writes shadow.
- Load at any other time writes shadow only. A later load before the frame start overwrites the earlier one; the last one wins.
- Blanking rule: digit i is blanked when lzb=1, i>0, and every nibble of disp from i to NUM_DIGITS-1 is zero. Digit 0 is never blanked by lzb, so a value of 0 shows a single "0".
- Outputs are registered and updated on each tick from the next idx and next disp values:
  - an = ~(1<<idx_next).
  - seg = decode(nibble), or 7'b0000000 if the digit is blanked.
- Decode table:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001
  - 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1111011, A:1110111, b:0011111
  - C:1001110, d:0111101, E:1001111, F:1000111
- en=0:
  - an is forced to all ones and seg to 0 at the next clock edge.
  - presc, idx, shadow and disp keep running.
  - When en returns to 1, outputs resume at the next tick.
- frame is asserted for exactly one cycle on the edge where idx becomes 0. It is independent of en.

## Timing
- Reset values:
  - presc=0; idx=NUM_DIGITS-1; shadow=0; disp=0.
  - an=all ones; seg=0; frame=0.
- Reset assertion clears all state immediately, regardless of clk. Any scan in progress is abandoned.
- First tick after reset release occurs REFRESH_DIV cycles later. It is a frame start: idx=0, frame=1, and digit 0 is displayed.
- Latency from load to visible digits:
  - At most NUM_DIGITS*REFRESH_DIV cycles.
  - Exactly 0 extra cycles when load coincides with a frame start, because of the bypass.
- Each digit is enabled for exactly REFRESH_DIV cycles. The frame period is NUM_DIGITS*REFRESH_DIV cycles.
- an and seg change on the same edge. There is no cycle in which the new an pairs with the old seg.

## Structure
- Package seg_pkg holds:
  - SEG_W=7 and SEG_BLANK=7'b0000000.
  - 16-entry constant table HEX_SEG[0:15] holding the codes above.
  - Function log2ceil, used to size presc and idx.
- Sub-module hex_seg_decoder: combinational, 4-bit in, 7-bit {a..g} out, built from HEX_SEG. Instantiated once and fed by the selected nibble of disp.
- The top level holds presc, idx, shadow, disp, the blanking logic and the output registers.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- Reset then idle, en=1, lzb=0:
  - an=1111 and seg=0 for 4 cycles.
  - Then frame=1, an=1110, seg=1111110.
  - an then steps 1101, 1011, 0111 every 4 cycles.
- load with 0x1234 mid-frame:
  - The current frame still shows 0000.
  - The next frame shows digit0 0110011, digit1 1111001, digit2 1101101, digit3 0110000.
- load 0x00A0 with lzb=1:
  - digit0 1111110, digit1 1110111.
  - digits 2 and 3 have seg=0.
  - load 0x0000 then shows digit0 1111110 and digits 1-3 blank.
- Simultaneous events:
  - load 0xBEEF in the same cycle as a frame tick: digit0 shows 1000111 in that frame.
  - Two loads (0x1111, then 0x2222) within one frame: only 0x2222 is displayed.
- en toggles low for 6 cycles mid-frame:
  - an=1111 and seg=0 from the next edge.
  - frame pulses stay periodic every 16 cycles.
  - Display resumes at the next tick.
- rst_n asserted asynchronously between clock edges during digit 2:
  - an=1111 and seg=0 immediately.
  - After release, the reset-sequence timing above repeats.
